// File: rtl/can_fault_confine.sv
// CAN fault-confinement unit: transmit/receive error counters, error-state
// FSM (error-active, warning, error-passive, bus-off, recovery) and the
// bus-off recovery sequence counter with optional host-gated restart.
module can_fault_confine #(
    parameter int unsigned CNT_W         = 9,
    parameter int unsigned WARN_LIMIT    = 96,
    parameter int unsigned PASSIVE_LIMIT = 128,
    parameter int unsigned BUSOFF_LIMIT  = 256,
    parameter int unsigned REC_RELOAD    = 120,
    parameter int unsigned RECOVERY_BITS = 11,
    parameter int unsigned RECOVERY_SEQ  = 128,
    parameter int unsigned AUTO_RECOVER  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tx_err,
    input  logic             tx_ok,
    input  logic             rx_err1,
    input  logic             rx_err8,
    input  logic             rx_ok,
    input  logic             bit_strobe,
    input  logic             bus_level,
    input  logic             restart_req,
    output logic [CNT_W-1:0] tec,
    output logic [CNT_W-1:0] rec,
    output logic             erroractive,
    output logic             errorpassive,
    output logic             busoff,
    output logic             warnsig,
    output logic             irqsig,
    output logic [2:0]       irq_cause,
    output logic [7:0]       seq_count
);

    typedef enum logic [2:0] {
        ERR_ACTIVE  = 3'b000,
        ERR_PASSIVE = 3'b001,
        BUS_OFF     = 3'b010,
        RECOVER     = 3'b011,
        WARNING     = 3'b100
    } state_t;

    localparam int unsigned RUN_W = $clog2(RECOVERY_BITS + 1);

    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_WARN    = CNT_W'(WARN_LIMIT);
    localparam logic [CNT_W-1:0] C_PASSIVE = CNT_W'(PASSIVE_LIMIT);
    localparam logic [CNT_W-1:0] C_BUSOFF  = CNT_W'(BUSOFF_LIMIT);
    localparam logic [CNT_W-1:0] C_REC_MAX = CNT_W'(BUSOFF_LIMIT - 1);
    localparam logic [CNT_W-1:0] C_RELOAD  = CNT_W'(REC_RELOAD);

    // Sums are formed one bit wider so saturation is decided before wrap.
    localparam logic [CNT_W:0] W_ONE     = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] W_EIGHT   = (CNT_W+1)'(8);
    localparam logic [CNT_W:0] W_BUSOFF  = (CNT_W+1)'(BUSOFF_LIMIT);
    localparam logic [CNT_W:0] W_REC_MAX = (CNT_W+1)'(BUSOFF_LIMIT - 1);

    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RECOVERY_BITS - 1);

    localparam logic [7:0] SEQ_ONE  = 8'd1;
    localparam logic [7:0] SEQ_DONE = 8'(RECOVERY_SEQ);

    localparam logic ARM_INIT = (AUTO_RECOVER != 0);

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   tec_upd;
    logic [CNT_W-1:0]   rec_upd;
    logic [CNT_W-1:0]   tec_n;
    logic [CNT_W-1:0]   rec_n;
    logic [CNT_W:0]     tec_sum8;
    logic [CNT_W:0]     rec_sum8;
    logic [CNT_W:0]     rec_sum1;
    logic [RUN_W-1:0]   run;
    logic [RUN_W-1:0]   run_n;
    logic [7:0]         seq_n;
    logic               armed;
    logic               armed_n;
    logic               tec_busoff;
    logic               any_passive;
    logic               any_warn;

    // Threshold flags taken from the registered counters.
    assign tec_busoff  = (tec >= C_BUSOFF);
    assign any_passive = (tec >= C_PASSIVE) || (rec >= C_PASSIVE);
    assign any_warn    = (tec >= C_WARN) || (rec >= C_WARN);

    // Status decode straight from the state register.
    assign erroractive  = (state == ERR_ACTIVE) || (state == WARNING) || (state == RECOVER);
    assign errorpassive = (state == ERR_PASSIVE);
    assign busoff       = (state == BUS_OFF);
    assign warnsig      = (state == WARNING);

    // Candidate TEC value from the transmit strobes (tx_err wins, clamps at bus-off limit).
    always_comb begin
        tec_sum8 = {1'b0, tec} + W_EIGHT;
        tec_upd  = tec;
        if (tx_err) begin
            tec_upd = (tec_sum8 >= W_BUSOFF) ? C_BUSOFF : tec_sum8[CNT_W-1:0];
        end else if (tx_ok && (tec != '0)) begin
            tec_upd = tec - C_ONE;
        end
    end

    // Candidate REC value from the receive strobes (err8 > err1 > ok).
    always_comb begin
        rec_sum8 = {1'b0, rec} + W_EIGHT;
        rec_sum1 = {1'b0, rec} + W_ONE;
        rec_upd  = rec;
        if (rx_err8) begin
            rec_upd = (rec_sum8 >= W_REC_MAX) ? C_REC_MAX : rec_sum8[CNT_W-1:0];
        end else if (rx_err1) begin
            rec_upd = (rec_sum1 >= W_REC_MAX) ? C_REC_MAX : rec_sum1[CNT_W-1:0];
        end else if (rx_ok) begin
            if (rec >= C_PASSIVE) begin
                rec_upd = C_RELOAD;
            end else if (rec != '0) begin
                rec_upd = rec - C_ONE;
            end
        end
    end

    // Next-state and next-counter selection for every error state.
    always_comb begin
        state_n = state;
        tec_n   = tec;
        rec_n   = rec;
        seq_n   = seq_count;
        run_n   = run;
        armed_n = armed;
        case (state)
            ERR_ACTIVE: begin
                tec_n = tec_upd;
                rec_n = rec_upd;
                if (tec_busoff) begin
                    state_n = BUS_OFF;
                end else if (any_passive) begin
                    state_n = ERR_PASSIVE;
                end else if (any_warn) begin
                    state_n = WARNING;
                end
            end
            WARNING: begin
                tec_n = tec_upd;
                rec_n = rec_upd;
                if (tec_busoff) begin
                    state_n = BUS_OFF;
                end else if (any_passive) begin
                    state_n = ERR_PASSIVE;
                end else if (!any_warn) begin
                    state_n = ERR_ACTIVE;
                end
            end
            ERR_PASSIVE: begin
                tec_n = tec_upd;
                rec_n = rec_upd;
                if (tec_busoff) begin
                    state_n = BUS_OFF;
                end else if (!any_passive) begin
                    state_n = any_warn ? WARNING : ERR_ACTIVE;
                end
            end
            BUS_OFF: begin
                if (seq_count >= SEQ_DONE) begin
                    state_n = RECOVER;
                end else begin
                    if (!armed && restart_req) begin
                        armed_n = 1'b1;
                    end
                    // A dominant bit breaks the current recessive run.
                    if (armed && bit_strobe) begin
                        if (!bus_level) begin
                            run_n = '0;
                        end else if (run == RUN_LAST) begin
                            run_n = '0;
                            seq_n = seq_count + SEQ_ONE;
                        end else begin
                            run_n = run + RUN_ONE;
                        end
                    end
                end
            end
            RECOVER: begin
                state_n = ERR_ACTIVE;
                tec_n   = '0;
                rec_n   = '0;
                seq_n   = '0;
                run_n   = '0;
                armed_n = ARM_INIT;
            end
            default: begin
                state_n = ERR_ACTIVE;
                tec_n   = '0;
                rec_n   = '0;
                seq_n   = '0;
                run_n   = '0;
                armed_n = ARM_INIT;
            end
        endcase
    end

    // State/counter registers with the state-change interrupt pulse and cause.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ERR_ACTIVE;
            tec       <= '0;
            rec       <= '0;
            seq_count <= '0;
            run       <= '0;
            armed     <= ARM_INIT;
            irqsig    <= 1'b0;
            irq_cause <= '0;
        end else begin
            state     <= state_n;
            tec       <= tec_n;
            rec       <= rec_n;
            seq_count <= seq_n;
            run       <= run_n;
            armed     <= armed_n;
            irqsig    <= (state_n != state);
            if (state_n != state) begin
                irq_cause <= state_n;
            end
        end
    end

endmodule

// File: tb/tb_can_fault_confine.sv
// Directed bench for can_fault_confine: one instance with automatic
// bus-off recovery, one with host-gated restart.
module tb_can_fault_confine;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A (AUTO_RECOVER = 1)
    logic       reset, tx_err, tx_ok, rx_err1, rx_err8, rx_ok;
    logic       bit_strobe, bus_level, restart_req;
    logic [8:0] tec, rec;
    logic       erroractive, errorpassive, busoff, warnsig, irqsig;
    logic [2:0] irq_cause;
    logic [7:0] seq_count;

    // Instance B (AUTO_RECOVER = 0)
    logic       b_reset, b_tx_err, b_tx_ok, b_rx_err1, b_rx_err8, b_rx_ok;
    logic       b_bit_strobe, b_bus_level, b_restart;
    logic [8:0] b_tec, b_rec;
    logic       b_erroractive, b_errorpassive, b_busoff, b_warnsig, b_irqsig;
    logic [2:0] b_irq_cause;
    logic [7:0] b_seq;

    int checks = 0;
    int passed = 0;

    can_fault_confine #(.AUTO_RECOVER(1)) dut_a (
        .clock(clock), .reset(reset), .tx_err(tx_err), .tx_ok(tx_ok),
        .rx_err1(rx_err1), .rx_err8(rx_err8), .rx_ok(rx_ok),
        .bit_strobe(bit_strobe), .bus_level(bus_level), .restart_req(restart_req),
        .tec(tec), .rec(rec), .erroractive(erroractive), .errorpassive(errorpassive),
        .busoff(busoff), .warnsig(warnsig), .irqsig(irqsig), .irq_cause(irq_cause),
        .seq_count(seq_count)
    );

    can_fault_confine #(.AUTO_RECOVER(0)) dut_b (
        .clock(clock), .reset(b_reset), .tx_err(b_tx_err), .tx_ok(b_tx_ok),
        .rx_err1(b_rx_err1), .rx_err8(b_rx_err8), .rx_ok(b_rx_ok),
        .bit_strobe(b_bit_strobe), .bus_level(b_bus_level), .restart_req(b_restart),
        .tec(b_tec), .rec(b_rec), .erroractive(b_erroractive), .errorpassive(b_errorpassive),
        .busoff(b_busoff), .warnsig(b_warnsig), .irqsig(b_irqsig), .irq_cause(b_irq_cause),
        .seq_count(b_seq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bits(input int n, input logic lvl);
        bit_strobe = 1'b1;
        bus_level  = lvl;
        tick(n);
        bit_strobe = 1'b0;
        bus_level  = 1'b1;
    endtask

    task automatic test_reset;
        {tx_err, tx_ok, rx_err1, rx_err8, rx_ok, bit_strobe, restart_req} = '0;
        bus_level = 1'b1;
        {b_tx_err, b_tx_ok, b_rx_err1, b_rx_err8, b_rx_ok, b_bit_strobe, b_restart} = '0;
        b_bus_level = 1'b1;
        reset = 1'b0;
        b_reset = 1'b0;
        tick(2);
        reset = 1'b1;
        b_reset = 1'b1;
        tick(1);
        checks++; if (tec !== 9'd0) $display("FAIL reset_tec: got %0d expected 0", tec); else passed++;
        checks++; if (rec !== 9'd0) $display("FAIL reset_rec: got %0d expected 0", rec); else passed++;
        checks++; if (seq_count !== 8'd0) $display("FAIL reset_seq: got %0d expected 0", seq_count); else passed++;
        checks++; if ({erroractive, errorpassive, busoff, warnsig} !== 4'b1000)
            $display("FAIL reset_status: got %b expected 1000", {erroractive, errorpassive, busoff, warnsig}); else passed++;
        checks++; if ({irqsig, irq_cause} !== 4'b0000)
            $display("FAIL reset_irq: got irq=%b cause=%b expected irq=0 cause=000", irqsig, irq_cause); else passed++;
    endtask

    task automatic test_priority;
        {tx_err, tx_ok, rx_err8, rx_err1, rx_ok} = 5'b11111;
        tick(1);
        {tx_err, tx_ok, rx_err8, rx_err1, rx_ok} = '0;
        checks++; if (tec !== 9'd8) $display("FAIL prio_tec: got %0d expected 8", tec); else passed++;
        checks++; if (rec !== 9'd8) $display("FAIL prio_rec8: got %0d expected 8", rec); else passed++;
        rx_err1 = 1'b1; rx_ok = 1'b1;
        tick(1);
        rx_err1 = 1'b0;
        checks++; if (rec !== 9'd9) $display("FAIL prio_rec1: got %0d expected 9", rec); else passed++;
        tx_ok = 1'b1;
        tick(8);
        checks++; if ({tec, rec} !== {9'd0, 9'd1})
            $display("FAIL dec_counters: got tec=%0d rec=%0d expected tec=0 rec=1", tec, rec); else passed++;
        tick(2);
        tx_ok = 1'b0; rx_ok = 1'b0;
        checks++; if ({tec, rec} !== {9'd0, 9'd0})
            $display("FAIL dec_floor: got tec=%0d rec=%0d expected tec=0 rec=0", tec, rec); else passed++;
        checks++; if ({erroractive, irqsig} !== 2'b10)
            $display("FAIL prio_state: got active=%b irq=%b expected active=1 irq=0", erroractive, irqsig); else passed++;
    endtask

    task automatic test_warning;
        tx_err = 1'b1;
        tick(12);
        tx_err = 1'b0;
        checks++; if ({tec, warnsig} !== {9'd96, 1'b0})
            $display("FAIL warn_pre: got tec=%0d warn=%b expected tec=96 warn=0", tec, warnsig); else passed++;
        tick(1);
        checks++; if ({warnsig, irqsig, irq_cause} !== 5'b11100)
            $display("FAIL warn_entry: got warn=%b irq=%b cause=%b expected 1 1 100", warnsig, irqsig, irq_cause); else passed++;
        tick(1);
        checks++; if (irqsig !== 1'b0) $display("FAIL warn_irq_pulse: got %b expected 0", irqsig); else passed++;
    endtask

    task automatic test_passive;
        int pulses;
        tx_err = 1'b1;
        tick(3);
        checks++; if (tec !== 9'd120) $display("FAIL pas_tec120: got %0d expected 120", tec); else passed++;
        tick(1);
        tx_err = 1'b0;
        checks++; if ({tec, errorpassive} !== {9'd128, 1'b0})
            $display("FAIL pas_pre: got tec=%0d passive=%b expected tec=128 passive=0", tec, errorpassive); else passed++;
        tick(1);
        checks++; if ({errorpassive, irqsig, irq_cause} !== 5'b11001)
            $display("FAIL pas_entry: got passive=%b irq=%b cause=%b expected 1 1 001", errorpassive, irqsig, irq_cause); else passed++;
        pulses = 0;
        tx_ok = 1'b1;
        for (int i = 0; i < 33; i++) begin
            tick(1);
            if (irqsig) pulses++;
        end
        tx_ok = 1'b0;
        checks++; if ({tec, warnsig, irq_cause} !== {9'd95, 1'b1, 3'b100})
            $display("FAIL pas_to_warn: got tec=%0d warn=%b cause=%b expected tec=95 warn=1 cause=100", tec, warnsig, irq_cause); else passed++;
        checks++; if (pulses !== 1) $display("FAIL pas_warn_pulses: got %0d expected 1", pulses); else passed++;
        tick(1);
        checks++; if ({erroractive, warnsig, irqsig, irq_cause} !== 6'b101000)
            $display("FAIL warn_to_active: got act=%b warn=%b irq=%b cause=%b expected 1 0 1 000", erroractive, warnsig, irqsig, irq_cause); else passed++;
    endtask

    task automatic test_rx;
        rx_err8 = 1'b1;
        tick(17);
        checks++; if ({rec, errorpassive} !== {9'd136, 1'b1})
            $display("FAIL rx_136: got rec=%0d passive=%b expected rec=136 passive=1", rec, errorpassive); else passed++;
        tick(15);
        checks++; if (rec !== 9'd255) $display("FAIL rx_sat: got %0d expected 255", rec); else passed++;
        tick(1);
        rx_err8 = 1'b0;
        checks++; if (rec !== 9'd255) $display("FAIL rx_sat_hold: got %0d expected 255", rec); else passed++;
        rx_ok = 1'b1;
        tick(1);
        rx_ok = 1'b0;
        checks++; if ({rec, errorpassive} !== {9'd120, 1'b1})
            $display("FAIL rx_reload: got rec=%0d passive=%b expected rec=120 passive=1", rec, errorpassive); else passed++;
        tick(1);
        checks++; if ({warnsig, irqsig, irq_cause} !== 5'b11100)
            $display("FAIL rx_to_warn: got warn=%b irq=%b cause=%b expected 1 1 100", warnsig, irqsig, irq_cause); else passed++;
        rx_ok = 1'b1;
        tick(25);
        rx_ok = 1'b0;
        tick(1);
        checks++; if ({rec, erroractive, warnsig} !== {9'd95, 1'b1, 1'b0})
            $display("FAIL rx_to_active: got rec=%0d act=%b warn=%b expected rec=95 act=1 warn=0", rec, erroractive, warnsig); else passed++;
    endtask

    task automatic test_busoff;
        tx_err = 1'b1;
        tick(21);
        checks++; if ({tec, busoff, errorpassive} !== {9'd256, 1'b0, 1'b1})
            $display("FAIL bo_clamp: got tec=%0d busoff=%b passive=%b expected 256 0 1", tec, busoff, errorpassive); else passed++;
        tick(1);
        checks++; if ({busoff, irqsig, irq_cause, tec} !== {1'b1, 1'b1, 3'b010, 9'd256})
            $display("FAIL bo_entry: got busoff=%b irq=%b cause=%b tec=%0d expected 1 1 010 256", busoff, irqsig, irq_cause, tec); else passed++;
        tx_ok = 1'b1; rx_err8 = 1'b1;
        tick(3);
        tx_err = 1'b0; rx_err8 = 1'b0;
        tick(2);
        tx_ok = 1'b0;
        checks++; if ({tec, rec, busoff} !== {9'd256, 9'd95, 1'b1})
            $display("FAIL bo_ignore: got tec=%0d rec=%0d busoff=%b expected 256 95 1", tec, rec, busoff); else passed++;
    endtask

    task automatic test_recovery;
        send_bits(110, 1'b1);
        checks++; if (seq_count !== 8'd10) $display("FAIL rcv_seq10: got %0d expected 10", seq_count); else passed++;
        send_bits(6, 1'b1);
        send_bits(1, 1'b0);
        send_bits(10, 1'b1);
        checks++; if (seq_count !== 8'd10) $display("FAIL rcv_dominant: got %0d expected 10", seq_count); else passed++;
        send_bits(1, 1'b1);
        checks++; if (seq_count !== 8'd11) $display("FAIL rcv_seq11: got %0d expected 11", seq_count); else passed++;
        send_bits(117 * 11, 1'b1);
        checks++; if ({seq_count, busoff} !== {8'd128, 1'b1})
            $display("FAIL rcv_done: got seq=%0d busoff=%b expected 128 1", seq_count, busoff); else passed++;
        tick(1);
        checks++; if ({busoff, erroractive, irqsig, irq_cause} !== 6'b011011)
            $display("FAIL rcv_recover: got busoff=%b act=%b irq=%b cause=%b expected 0 1 1 011", busoff, erroractive, irqsig, irq_cause); else passed++;
        tick(1);
        checks++; if ({irqsig, irq_cause, erroractive} !== 5'b10001)
            $display("FAIL rcv_active: got irq=%b cause=%b act=%b expected 1 000 1", irqsig, irq_cause, erroractive); else passed++;
        checks++; if ({tec, rec, seq_count} !== {9'd0, 9'd0, 8'd0})
            $display("FAIL rcv_clear: got tec=%0d rec=%0d seq=%0d expected 0 0 0", tec, rec, seq_count); else passed++;
    endtask

    task automatic b_enter_busoff;
        b_tx_err = 1'b1;
        tick(33);
        b_tx_err = 1'b0;
    endtask

    task automatic b_bits(input int n);
        b_bit_strobe = 1'b1;
        b_bus_level  = 1'b1;
        tick(n);
        b_bit_strobe = 1'b0;
    endtask

    task automatic test_manual_restart;
        b_restart = 1'b1;
        tick(1);
        b_restart = 1'b0;
        b_enter_busoff();
        checks++; if ({b_busoff, b_tec} !== {1'b1, 9'd256})
            $display("FAIL man_busoff: got busoff=%b tec=%0d expected 1 256", b_busoff, b_tec); else passed++;
        b_bits(22);
        checks++; if (b_seq !== 8'd0) $display("FAIL man_unarmed: got %0d expected 0", b_seq); else passed++;
        b_restart = 1'b1;
        tick(1);
        b_restart = 1'b0;
        b_bits(550);
        checks++; if (b_seq !== 8'd50) $display("FAIL man_seq50: got %0d expected 50", b_seq); else passed++;
        b_reset = 1'b0;
        tick(1);
        b_reset = 1'b1;
        checks++; if ({b_tec, b_rec, b_seq} !== {9'd0, 9'd0, 8'd0})
            $display("FAIL man_reset_cnt: got tec=%0d rec=%0d seq=%0d expected 0 0 0", b_tec, b_rec, b_seq); else passed++;
        checks++; if ({b_erroractive, b_errorpassive, b_busoff, b_warnsig, b_irqsig, b_irq_cause} !== 8'b10000000)
            $display("FAIL man_reset_status: got %b expected 10000000",
                     {b_erroractive, b_errorpassive, b_busoff, b_warnsig, b_irqsig, b_irq_cause}); else passed++;
        b_enter_busoff();
        b_bits(22);
        checks++; if ({b_busoff, b_seq} !== {1'b1, 8'd0})
            $display("FAIL man_rearm_needed: got busoff=%b seq=%0d expected 1 0", b_busoff, b_seq); else passed++;
        b_restart = 1'b1;
        tick(1);
        b_restart = 1'b0;
        b_bits(11);
        checks++; if (b_seq !== 8'd1) $display("FAIL man_restart2: got %0d expected 1", b_seq); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_priority();
        test_warning();
        test_passive();
        test_rx();
        test_busoff();
        test_recovery();
        test_manual_restart();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
